// File: rtl/alu_issue.sv
// RV32I integer-computational issue stage: decodes into ALU operands/operation and presents
// them registered to execute, with a two-entry skid buffer for full throughput.

package common;
    typedef enum logic [3:0] {
        AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd, AluLui
    } alu_operation_type;
endpackage

module alu_issue
    import common::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_rs1_data,
    input  logic [DATA_WIDTH-1:0] in_rs2_data,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [DATA_WIDTH-1:0] ex_a,
    output logic [DATA_WIDTH-1:0] ex_b,
    output alu_operation_type     ex_op,
    output logic [4:0]            ex_rd,
    output logic                  ex_wb_en,
    output logic                  ex_illegal
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        alu_operation_type     op;
        logic [4:0]            rd;
        logic                  wb_en;
        logic                  illegal;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e state_q, state_d;
    entry_t out_q, out_d, skid_q, skid_d, dec;

    logic [6:0]            opcode, funct7;
    logic [2:0]            funct3;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] imm_i, shamt_i, shamt_r;
    logic                  is_shift, legal;
    alu_operation_type     base_op, dec_op;
    logic [DATA_WIDTH-1:0] dec_a, dec_b;
    logic                  in_xfer, out_xfer;
    logic                  unused_rs1_idx;

    assign opcode   = in_instr[6:0];
    assign rd       = in_instr[11:7];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign imm_i    = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
    assign shamt_i  = {{(DATA_WIDTH-5){1'b0}}, in_instr[24:20]};
    assign shamt_r  = {{(DATA_WIDTH-5){1'b0}}, in_rs2_data[4:0]};
    assign is_shift = (funct3[1:0] == 2'b01);
    // Register indices are resolved upstream; only the data arrives here.
    assign unused_rs1_idx = ^in_instr[19:15];

    always_comb begin
        base_op = AluAdd;
        unique case (funct3)
            3'b000: base_op = AluAdd;
            3'b001: base_op = AluSll;
            3'b010: base_op = AluSlt;
            3'b011: base_op = AluSltu;
            3'b100: base_op = AluXor;
            3'b101: base_op = AluSrl;
            3'b110: base_op = AluOr;
            3'b111: base_op = AluAnd;
            default: base_op = AluAdd;
        endcase
    end

    always_comb begin
        legal  = 1'b0;
        dec_op = AluAdd;
        dec_a  = in_rs1_data;
        dec_b  = in_rs2_data;
        unique case (opcode)
            7'b0110111: begin
                legal  = 1'b1;
                dec_op = AluLui;
                dec_a  = '0;
                dec_b  = {{(DATA_WIDTH-20){1'b0}}, in_instr[31:12]};
            end
            7'b0010111: begin
                legal = 1'b1;
                dec_a = in_pc;
                dec_b = {in_instr[31:12], 12'b0};
            end
            7'b0010011: begin
                legal  = !is_shift || funct7 == 7'b0000000
                         || (funct3 == 3'b101 && funct7 == 7'b0100000);
                dec_op = (funct3 == 3'b101 && funct7[5]) ? AluSra : base_op;
                dec_b  = is_shift ? shamt_i : imm_i;
            end
            7'b0110011: begin
                dec_b = is_shift ? shamt_r : in_rs2_data;
                if (funct7 == 7'b0000000) begin
                    legal  = 1'b1;
                    dec_op = base_op;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    legal  = 1'b1;
                    dec_op = AluSub;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    legal  = 1'b1;
                    dec_op = AluSra;
                end
            end
            default: legal = 1'b0;
        endcase

        dec.a       = legal ? dec_a : '0;
        dec.b       = legal ? dec_b : '0;
        dec.op      = legal ? dec_op : AluAdd;
        dec.rd      = rd;
        dec.wb_en   = legal && (rd != 5'd0);
        dec.illegal = !legal;
    end

    assign ex_valid = (state_q != StEmpty);
    // Derived purely from the state flop so it never depends on ex_ready combinationally.
    assign in_ready = (state_q != StTwo);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = ex_valid && ex_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    state_d = StOne;
                    out_d   = dec;
                end
            end
            StOne: begin
                if (in_xfer && out_xfer) begin
                    out_d = dec;
                end else if (in_xfer) begin
                    state_d = StTwo;
                    skid_d  = dec;
                end else if (out_xfer) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (out_xfer) begin
                    state_d = StOne;
                    out_d   = skid_q;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign ex_a       = out_q.a;
    assign ex_b       = out_q.b;
    assign ex_op      = out_q.op;
    assign ex_rd      = out_q.rd;
    assign ex_wb_en   = out_q.wb_en;
    assign ex_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: queue-based reference model checked every cycle, plus directed
// vectors with literal expectations, back-pressure, random handshake and mid-run reset.

module tb_alu_issue;
    import common::*;

    typedef struct {
        logic [31:0]       a;
        logic [31:0]       b;
        alu_operation_type op;
        logic [4:0]        rd;
        logic              wb;
        logic              ill;
    } exp_t;

    logic              clk, rst_n;
    logic              in_valid, in_ready, ex_valid, ex_ready;
    logic [31:0]       in_instr, in_pc, in_rs1_data, in_rs2_data, ex_a, ex_b;
    alu_operation_type ex_op;
    logic [4:0]        ex_rd;
    logic              ex_wb_en, ex_illegal;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t model_q[$];
    alu_operation_type base_ops[8] =
        '{AluAdd, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluOr, AluAnd};

    alu_issue #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_rs1_data(in_rs1_data),
        .in_rs2_data(in_rs2_data),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .ex_op      (ex_op),
        .ex_rd      (ex_rd),
        .ex_wb_en   (ex_wb_en),
        .ex_illegal (ex_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decoder written from the instruction-set rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] immi;
        opc  = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        immi = {{20{ins[31]}}, ins[31:20]};
        e.rd = ins[11:7];
        e.ill = 1'b1;
        e.op = AluAdd;
        e.a = 0;
        e.b = 0;
        if (opc == 7'h37) begin
            e.ill = 0; e.op = AluLui; e.b = ins >> 12;
        end else if (opc == 7'h17) begin
            e.ill = 0; e.a = pc; e.b = ins & 32'hFFFF_F000;
        end else if (opc == 7'h13) begin
            e.ill = 0; e.a = r1; e.b = immi; e.op = base_ops[f3];
            if (f3 == 1) begin
                e.b = ins[24:20]; e.ill = (f7 != 0);
            end else if (f3 == 5) begin
                e.b = ins[24:20];
                e.op = (f7 == 7'h20) ? AluSra : AluSrl;
                e.ill = !(f7 == 0 || f7 == 7'h20);
            end
        end else if (opc == 7'h33) begin
            e.a = r1; e.b = r2;
            if (f3 == 1 || f3 == 5) e.b = r2 & 32'h1F;
            if (f7 == 0) begin
                e.ill = 0; e.op = base_ops[f3];
            end else if (f7 == 7'h20 && f3 == 0) begin
                e.ill = 0; e.op = AluSub;
            end else if (f7 == 7'h20 && f3 == 5) begin
                e.ill = 0; e.op = AluSra;
            end
        end
        if (e.ill) begin
            e.a = 0; e.b = 0; e.op = AluAdd;
        end
        e.wb = !e.ill && e.rd != 0;
        return e;
    endfunction

    // Compare process: state of the buffer is just the model queue's occupancy.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ex_valid", 32'(ex_valid), 32'(model_q.size() > 0));
            check("in_ready", 32'(in_ready), 32'(model_q.size() < 2));
            if (model_q.size() > 0 && ex_valid) begin
                check("ex_a", ex_a, model_q[0].a);
                check("ex_b", ex_b, model_q[0].b);
                check("ex_op", 32'(ex_op), 32'(model_q[0].op));
                check("ex_rd", 32'(ex_rd), 32'(model_q[0].rd));
                check("ex_wb_en", 32'(ex_wb_en), 32'(model_q[0].wb));
                check("ex_illegal", 32'(ex_illegal), 32'(model_q[0].ill));
            end
            if (ex_valid && ex_ready && model_q.size() > 0) void'(model_q.pop_front());
            if (in_valid && in_ready)
                model_q.push_back(model(in_instr, in_pc, in_rs1_data, in_rs2_data));
        end
    end

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        in_instr = ins; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
    endtask

    // Send one instruction into an empty stage and check the presented entry literally.
    task automatic directed(input string nm, input logic [31:0] ins, input logic [31:0] pc,
                            input logic [31:0] r1, input logic [31:0] r2,
                            input logic [31:0] ea, input logic [31:0] eb,
                            input alu_operation_type eop, input logic [4:0] erd,
                            input logic ewb, input logic eill);
        @(posedge clk); #1;
        drive(ins, pc, r1, r2);
        in_valid = 1'b1;
        ex_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({nm, ".valid"}, 32'(ex_valid), 32'd1);
        check({nm, ".a"}, ex_a, ea);
        check({nm, ".b"}, ex_b, eb);
        check({nm, ".op"}, 32'(ex_op), 32'(eop));
        check({nm, ".rd"}, 32'(ex_rd), 32'(erd));
        check({nm, ".wb"}, 32'(ex_wb_en), 32'(ewb));
        check({nm, ".ill"}, 32'(ex_illegal), 32'(eill));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd);
        return (32'd1 << 20) | (32'd1 << 15) | (32'(rd) << 7) | 32'h13;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0] opcs[5] = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h0B};
        logic [6:0] f7s[4] = '{7'h00, 7'h20, 7'h01, 7'h00};
        w = $urandom;
        w[6:0] = opcs[$urandom_range(0, 4)];
        if ($urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 3)];
        if ($urandom_range(0, 15) == 0) w[1:0] = 2'($urandom_range(0, 2));
        return w;
    endfunction

    initial begin
        exp_t       m;
        logic [31:0] hold_a, hold_b, hold_rd;
        int         acc, nxt_rd, emitted, cyc;
        logic       fire;

        rst_n = 1'b0; in_valid = 1'b0; ex_ready = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        #3;
        check("rst.ex_valid", 32'(ex_valid), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.ex_a", ex_a, 32'd0);
        check("rst.ex_b", ex_b, 32'd0);
        check("rst.ex_op", 32'(ex_op), 32'(AluAdd));
        check("rst.ex_rd", 32'(ex_rd), 32'd0);
        check("rst.wb_ill", {30'd0, ex_wb_en, ex_illegal}, 32'd0);
        #9 rst_n = 1'b1;

        // Pin the model against hand-derived encodings.
        m = model(32'h40415193, 0, 32'h8000_0000, 0);
        check("model.srai", {m.a[31:28], m.b[27:0]}, {4'h8, 28'd4});
        m = model(32'h022080B3, 0, 1, 2);
        check("model.mul", {31'd0, m.ill}, 32'd1);

        directed("addi", 32'hFFF08293, 0, 32'h10, 0, 32'h10, 32'hFFFF_FFFF, AluAdd, 5, 1, 0);
        directed("srai", 32'h40415193, 0, 32'h8000_0000, 0, 32'h8000_0000, 32'd4, AluSra, 3,
                 1, 0);
        directed("lui", 32'h123453B7, 0, 32'h5, 32'h6, 32'd0, 32'h0001_2345, AluLui, 7, 1, 0);
        directed("auipc", 32'h00001517, 32'h100, 32'h5, 0, 32'h100, 32'h1000, AluAdd, 10, 1, 0);
        directed("mul", 32'h022080B3, 0, 32'h7, 32'h9, 32'd0, 32'd0, AluAdd, 1, 0, 1);
        directed("sub_x0", 32'h40208033, 0, 32'h7, 32'h9, 32'h7, 32'h9, AluSub, 0, 0, 0);
        directed("sll_r", 32'h002090B3, 0, 32'h1, 32'hFFFF_FFE3, 32'h1, 32'h3, AluSll, 1, 1, 0);
        directed("slli_bad", 32'h02109093, 0, 32'h1, 0, 32'd0, 32'd0, AluAdd, 1, 0, 1);
        directed("bad_lsb", 32'h00108292, 0, 32'h1, 0, 32'd0, 32'd0, AluAdd, 5, 0, 1);

        // Back-pressure: stall 4 cycles with a stream of ADDIs, then release.
        ex_ready = 1'b0; acc = 0; nxt_rd = 1;
        drive(addi(5'(nxt_rd)), 0, 32'h10, 0); in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            fire = in_valid && in_ready;
            if (c == 2) begin
                hold_a = ex_a; hold_b = ex_b; hold_rd = 32'(ex_rd);
            end
            if (c == 3) begin
                check("stall.a", ex_a, hold_a);
                check("stall.b", ex_b, hold_b);
                check("stall.rd", hold_rd, 32'd1);
                check("stall.in_ready", 32'(in_ready), 32'd0);
            end
            @(posedge clk); #1;
            if (fire) begin
                acc++; nxt_rd++; drive(addi(5'(nxt_rd)), 0, 32'h10, 0);
            end
        end
        check("stall.accepted", 32'(acc), 32'd2);
        ex_ready = 1'b1; emitted = 1; cyc = 0;
        while (emitted <= 8 && cyc < 50) begin
            @(negedge clk);
            fire = in_valid && in_ready;
            if (ex_valid && ex_ready) begin
                check("bp.order", 32'(ex_rd), 32'(emitted));
                emitted++;
            end
            @(posedge clk); #1;
            cyc++;
            if (fire) begin
                nxt_rd++; drive(addi(5'(nxt_rd)), 0, 32'h10, 0);
                if (nxt_rd > 8) in_valid = 1'b0;
            end
        end
        check("bp.budget", 32'(emitted), 32'd9);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Random handshake over 1000 accepted instructions.
        acc = 0; cyc = 0;
        drive(rand_instr(), $urandom, $urandom, $urandom);
        while (acc < 1000 && cyc < 20000) begin
            in_valid = 1'($urandom_range(0, 1));
            ex_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (fire) begin
                acc++; drive(rand_instr(), $urandom, $urandom, $urandom);
            end
        end
        check("rand.budget", 32'(acc), 32'd1000);
        in_valid = 1'b0; ex_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Reset mid-operation with two entries buffered.
        ex_ready = 1'b0; in_valid = 1'b1;
        drive(addi(5'd20), 0, 0, 0);
        @(posedge clk); #1;
        drive(addi(5'd21), 0, 0, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst.in_ready", 32'(in_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst.ex_valid", 32'(ex_valid), 32'd0);
        check("mid_rst.in_ready", 32'(in_ready), 32'd1);
        model_q.delete();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(addi(5'd22), 0, 32'h3, 0); in_valid = 1'b1; ex_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("post_rst.rd", 32'(ex_rd), 32'd22);
        check("post_rst.a", ex_a, 32'h3);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
